// File: rtl/mem_pkg.sv
// Shared types for the main-memory refill responder: FSM states and the
// latched request record.
package mem_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_IDX_W     = 30;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_WAIT
   } mem_state_t;

   typedef struct packed {
      logic                      wr;
      logic                      burst;
      logic [WORD_IDX_W-1:0]     idx;
      logic [31:0]               data;
      logic [BYTES_PER_WORD-1:0] be;
   } mem_req_t;

endpackage

// File: rtl/mem_bank_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-first data output.
module mem_bank_be
   import mem_pkg::*;
#(
   parameter int WORDS = 4096,
   parameter int IDX_W = $clog2(WORDS)
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [BYTES_PER_WORD-1:0] be,
   input  logic [IDX_W-1:0]          addr,
   input  logic [31:0]               wdata,
   output logic [31:0]               rdata
);

   logic [31:0] mem [WORDS];

   // NOTE: the array and its read register have no reset; clearing a RAM
   // would prevent mapping it onto a memory macro.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
         if (we && be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_refill_responder.sv
// Fixed-latency main-memory responder: single/burst reads (critical word
// first, wrapping in the line) and byte-enabled word writes.
module mem_refill_responder
   import mem_pkg::*;
#(
   parameter int MEM_WORDS  = 4096,
   parameter int RD_LATENCY = 4,
   parameter int WR_LATENCY = 2,
   parameter int BURST_LEN  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_en_i,
   input  logic        req_burst_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wr_data_i,
   input  logic [3:0]  req_byte_en_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_last_o,
   output logic        wr_done_o
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int CNT_W = $clog2(RD_LATENCY + BURST_LEN + WR_LATENCY + 2);

   // Cycle offsets counted from the accept cycle (offset 0).
   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
   localparam logic [CNT_W-1:0] RD_ISSUE_K  = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_COMMIT_K = CNT_W'(WR_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_DONE_K   = CNT_W'(WR_LATENCY);
   localparam logic [CNT_W-1:0] BURST_BEATS = CNT_W'(BURST_LEN);
   localparam logic [IDX_W-1:0] LINE_MASK   = IDX_W'(BURST_LEN - 1);

   mem_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] k_cur, beat, n_beats, last_k;
   logic             live;
   logic             accept;
   mem_req_t         req_q, fresh, cur;
   logic [IDX_W-1:0] base, beat_off, ram_addr;
   logic             ram_we;
   logic [31:0]      ram_rdata;
   logic             unused_idx_bits;

   assign accept = req_valid_i && req_ready_o;

   always_comb begin
      fresh.wr    = req_wr_en_i;
      fresh.burst = req_burst_i;
      fresh.idx   = req_addr_i[31:2];
      fresh.data  = req_wr_data_i;
      fresh.be    = req_byte_en_i;
   end

   // In IDLE the request on the inputs is the live one, so a latency of 1
   // can drive the RAM port in the accept cycle itself.
   assign cur   = (state == IDLE) ? fresh : req_q;
   assign k_cur = (state == IDLE) ? '0 : cnt;

   assign base     = cur.idx[IDX_W-1:0];
   assign beat     = k_cur - RD_ISSUE_K;
   assign beat_off = IDX_W'(beat);
   assign ram_addr = cur.wr ? base
                            : ((base & ~LINE_MASK) | ((base + beat_off) & LINE_MASK));

   assign n_beats = (cur.burst && !cur.wr) ? BURST_BEATS : ONE;
   assign last_k  = RD_ISSUE_K + n_beats;

   assign ram_we = cur.wr && (k_cur == WR_COMMIT_K)
                   && ((state == IDLE) ? accept : (state == WR_WAIT));

   assign unused_idx_bits = ^cur.idx[WORD_IDX_W-1:IDX_W];

   mem_bank_be #(
      .WORDS (MEM_WORDS),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk   (clk),
      .we    (ram_we),
      .be    (cur.be),
      .addr  (ram_addr),
      .wdata (cur.data),
      .rdata (ram_rdata)
   );

   // NOTE: every variable gets a default before the case so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (accept) begin
               cnt_next = ONE;
               if (req_wr_en_i)          state_next = WR_WAIT;
               else if (RD_LATENCY == 1) state_next = RD_BURST;
               else                      state_next = RD_WAIT;
            end
         end
         RD_WAIT: begin
            cnt_next = cnt + ONE;
            if (cnt == RD_ISSUE_K) state_next = RD_BURST;
         end
         RD_BURST: begin
            if (cnt == last_k) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + ONE;
            end
         end
         WR_WAIT: begin
            if (cnt == WR_DONE_K) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + ONE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         live  <= 1'b0;
         req_q <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         live  <= 1'b1;
         if (accept) req_q <= fresh;
      end
   end

   // live holds ready low through reset until the first clock edge after it.
   assign req_ready_o = live && (state == IDLE);
   assign rsp_valid_o = (state == RD_BURST);
   assign rsp_last_o  = rsp_valid_o && (cnt == last_k);
   assign rsp_data_o  = rsp_valid_o ? ram_rdata : '0;
   assign wr_done_o   = (state == WR_WAIT) && (cnt == WR_DONE_K);

endmodule
